// File: rtl/viterbi_acs.sv
// Add-compare-select stage of a K=3, rate-1/2 (g0=111, g1=101) hard-decision Viterbi decoder.
// Feeds chosen predecessors to the survivor memory, then flushes it and reports the best end state.
module viterbi_acs #(
  parameter int FRAME_LEN = 8,
  parameter int PM_W      = 5,
  parameter int INIT_PM   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [1:0] sym,
  output logic       in_ready,
  output logic       en_mem,
  output logic [1:0] prv_st_00,
  output logic [1:0] prv_st_01,
  output logic [1:0] prv_st_10,
  output logic [1:0] prv_st_11,
  output logic [1:0] best_st,
  output logic       done,
  output logic       busy
);

  localparam int                CNT_W   = $clog2(FRAME_LEN + 1);
  localparam int                W1      = PM_W + 1;
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(FRAME_LEN - 1);
  localparam logic [W1-1:0]     PM_MAX  = W1'((1 << PM_W) - 1);
  localparam logic [PM_W-1:0]   PM_INIT = PM_W'(INIT_PM);

  typedef enum logic [1:0] {IDLE = 2'd0, ACS = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_e;

  state_e                state_q, state_d;
  logic [3:0][PM_W-1:0]  pm_q, pm_d;
  logic [3:0][1:0]       prv_q, prv_d;
  logic [CNT_W-1:0]      sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic [1:0]            best_q, best_d;
  logic                  en_mem_q, en_mem_d;
  logic                  done_q, done_d;

  logic                  accept_s;
  logic [3:0][W1-1:0]    cand_s;
  logic [3:0][1:0]       prv_acs_s;
  logic [3:0][PM_W-1:0]  pm_acs_s;
  logic [W1-1:0]         min_s, ca_s, cb_s, diff_s;
  logic [1:0]            ns_s, pa_s, pb_s, best_acs_s;

  // Hamming distance between the received symbol and the branch output leaving pred on input u
  function automatic logic [1:0] bm_f(input logic [1:0] rx, input logic [1:0] pred, input logic u);
    logic c0, c1;
    c0 = u ^ pred[1] ^ pred[0];
    c1 = u ^ pred[0];
    return {1'b0, rx[1] ^ c0} + {1'b0, rx[0] ^ c1};
  endfunction

  assign accept_s = in_valid && (state_q == ACS);

  // Butterfly: new state {u,s1} chooses between {s1,0} and {s1,1}, lower index wins ties
  always_comb begin
    cand_s     = '0;
    prv_acs_s  = '0;
    pm_acs_s   = '0;
    ns_s       = 2'd0;
    pa_s       = 2'd0;
    pb_s       = 2'd0;
    ca_s       = '0;
    cb_s       = '0;
    diff_s     = '0;
    best_acs_s = 2'd0;
    for (int n = 0; n < 4; n++) begin
      ns_s = 2'(n);
      pa_s = {ns_s[0], 1'b0};
      pb_s = {ns_s[0], 1'b1};
      ca_s = {1'b0, pm_q[pa_s]} + W1'(bm_f(sym, pa_s, ns_s[1]));
      cb_s = {1'b0, pm_q[pb_s]} + W1'(bm_f(sym, pb_s, ns_s[1]));
      if (cb_s < ca_s) begin
        cand_s[n]    = cb_s;
        prv_acs_s[n] = pb_s;
      end else begin
        cand_s[n]    = ca_s;
        prv_acs_s[n] = pa_s;
      end
    end
    min_s = cand_s[0];
    for (int n = 1; n < 4; n++) begin
      if (cand_s[n] < min_s) min_s = cand_s[n];
      else                   min_s = min_s;
    end
    for (int n = 0; n < 4; n++) begin
      diff_s      = cand_s[n] - min_s;
      pm_acs_s[n] = (diff_s > PM_MAX) ? PM_MAX[PM_W-1:0] : diff_s[PM_W-1:0];
    end
    for (int n = 1; n < 4; n++) begin
      if (pm_acs_s[n] < pm_acs_s[best_acs_s]) best_acs_s = 2'(n);
      else                                    best_acs_s = best_acs_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACS; else state_d = IDLE;
      ACS:     if (accept_s && (sym_cnt_q == LAST)) state_d = FLUSH; else state_d = ACS;
      FLUSH:   if (flush_cnt_q == LAST) state_d = DONE; else state_d = FLUSH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    pm_d        = pm_q;
    prv_d       = prv_q;
    sym_cnt_d   = sym_cnt_q;
    flush_cnt_d = flush_cnt_q;
    best_d      = best_q;
    en_mem_d    = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pm_d        = {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};
          sym_cnt_d   = '0;
          flush_cnt_d = '0;
        end else begin
          pm_d = pm_q;
        end
      end
      ACS: begin
        if (accept_s) begin
          pm_d      = pm_acs_s;
          prv_d     = prv_acs_s;
          en_mem_d  = 1'b1;
          sym_cnt_d = sym_cnt_q + CNT_W'(1);
          if (sym_cnt_q == LAST) best_d = best_acs_s;
          else                   best_d = best_q;
        end else begin
          en_mem_d = 1'b0;
        end
      end
      FLUSH: begin
        en_mem_d    = 1'b1;
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      DONE:    done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  // Metric, survivor and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_q        <= '0;
      prv_q       <= '0;
      sym_cnt_q   <= '0;
      flush_cnt_q <= '0;
      best_q      <= 2'd0;
      en_mem_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pm_q        <= pm_d;
      prv_q       <= prv_d;
      sym_cnt_q   <= sym_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      best_q      <= best_d;
      en_mem_q    <= en_mem_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = (state_q == ACS);
  assign busy      = (state_q != IDLE);
  assign en_mem    = en_mem_q;
  assign done      = done_q;
  assign best_st   = best_q;
  assign prv_st_00 = prv_q[0];
  assign prv_st_01 = prv_q[1];
  assign prv_st_10 = prv_q[2];
  assign prv_st_11 = prv_q[3];

endmodule

// File: tb/tb_viterbi_acs.sv
// Scoreboard bench for viterbi_acs: stimulus queues hand-computed expectations,
// a negedge monitor captures the survivor history, traces back and compares.
module tb_viterbi_acs;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid;
  logic [1:0] sym;
  logic       in_ready, en_mem, done, busy;
  logic [1:0] prv_st_00, prv_st_01, prv_st_10, prv_st_11, best_st;

  viterbi_acs #(.FRAME_LEN(8), .PM_W(5), .INIT_PM(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .sym(sym),
    .in_ready(in_ready), .en_mem(en_mem),
    .prv_st_00(prv_st_00), .prv_st_01(prv_st_01), .prv_st_10(prv_st_10), .prv_st_11(prv_st_11),
    .best_st(best_st), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int step; logic [3:0] mask; logic [7:0] prv; } step_t;
  typedef struct { logic [1:0] best; logic [7:0] bits; int gap; } frame_t;

  step_t  sq[$];
  frame_t fq[$];
  int n_cmp = 0;
  int n_bad = 0;

  int         mon_step = 0, en_hi = 0, gap_cnt = 0, busy_cnt = 0, done_cnt = 0;
  logic [7:0] hist [8];
  logic [7:0] cur_prv, msk, dec;
  logic [1:0] tb_s;
  step_t      st_item;
  frame_t     fr_item;

  assign cur_prv = {prv_st_11, prv_st_10, prv_st_01, prv_st_00};

  localparam logic [15:0] ZERO  = 16'b00_00_00_00_00_00_00_00;
  localparam logic [15:0] CLEAN = 16'b11_10_00_01_01_11_00_00;
  localparam logic [15:0] ERR   = 16'b11_10_10_01_01_11_00_00;
  localparam logic [15:0] TIE   = 16'b01_00_00_00_00_00_00_00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: collects survivor history, checks queued per-step and per-frame expectations
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_step = 0; en_hi = 0; gap_cnt = 0; busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (en_mem) begin
        en_hi++;
        if (mon_step < 8) begin
          hist[mon_step] = cur_prv;
          mon_step++;
          while (sq.size() > 0 && sq[0].step == mon_step) begin
            st_item = sq.pop_front();
            msk = {{2{st_item.mask[3]}}, {2{st_item.mask[2]}}, {2{st_item.mask[1]}}, {2{st_item.mask[0]}}};
            check($sformatf("prv_step%0d", mon_step), 32'(cur_prv & msk), 32'(st_item.prv & msk));
          end
        end
      end else if (mon_step > 0 && mon_step < 8) begin
        gap_cnt++;
        check("prv_hold_in_gap", 32'(cur_prv), 32'(hist[mon_step-1]));
      end
      if (done) begin
        done_cnt++;
        check("frame_expected", 32'(fq.size() > 0), 32'd1);
        if (fq.size() > 0) begin
          fr_item = fq.pop_front();
          tb_s = best_st;
          for (int k = 7; k >= 0; k--) begin
            dec[7-k] = tb_s[1];
            tb_s = hist[k][{tb_s, 1'b0} +: 2];
          end
          check("best_st", 32'(best_st), 32'(fr_item.best));
          check("traceback_bits", 32'(dec), 32'(fr_item.bits));
          check("en_mem_high_cycles", 32'(en_hi), 32'd16);
          check("en_mem_gap_cycles", 32'(gap_cnt), 32'(fr_item.gap));
          check("busy_cycles", 32'(busy_cnt), 32'(17 + fr_item.gap));
        end
        mon_step = 0; en_hi = 0; gap_cnt = 0; busy_cnt = 0;
      end
    end
  end

  task automatic push_clean_steps();
    sq.push_back('{1, 4'b0100, 8'b00_00_00_00});
    sq.push_back('{2, 4'b0010, 8'b00_00_10_00});
    sq.push_back('{3, 4'b1111, 8'b11_01_11_01});
    sq.push_back('{4, 4'b1000, 8'b10_00_00_00});
  endtask

  task automatic run_frame(input logic [15:0] syms, input int gap_before, input int gap_len,
                           input logic valid_on_start);
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; in_valid = valid_on_start; sym = 2'b11;
    for (int i = 0; i < 8; i++) begin
      if (i == gap_before) begin
        for (int g = 0; g < gap_len; g++) begin
          @(posedge clk); #1;
          start = 1'b1; in_valid = 1'b0; sym = 2'b11;
        end
      end
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b1; sym = syms[15-2*i -: 2];
    end
    @(posedge clk); #1;
    in_valid = 1'b0; sym = 2'b00;
    for (int c = 0; c < 100; c++) begin
      if (done_cnt != d0) break;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    check("done_single_pulse", 32'(done_cnt), 32'(d0 + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; sym = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({in_ready, en_mem, cur_prv, best_st, done, busy}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready_busy", 32'({in_ready, busy}), 32'd0);

    // zero frame; symbol offered in the start cycle must be ignored
    sq.push_back('{1, 4'b1111, 8'b10_00_10_00});
    for (int k = 2; k <= 8; k++) sq.push_back('{k, 4'b0001, 8'b00_00_00_00});
    fq.push_back('{2'b00, 8'b0000_0000, 0});
    run_frame(ZERO, 99, 0, 1'b1);

    push_clean_steps();
    fq.push_back('{2'b00, 8'b1011_0000, 0});
    run_frame(CLEAN, 99, 0, 1'b0);

    fq.push_back('{2'b00, 8'b1011_0000, 0});
    run_frame(ERR, 99, 0, 1'b0);

    // three idle cycles after symbol 4, with start asserted during the gap
    push_clean_steps();
    fq.push_back('{2'b00, 8'b1011_0000, 3});
    run_frame(CLEAN, 4, 3, 1'b0);

    sq.push_back('{1, 4'b1111, 8'b10_00_11_00});
    fq.push_back('{2'b00, 8'b0000_0000, 0});
    run_frame(TIE, 99, 0, 1'b0);

    // abort after five accepted symbols
    begin
      int d0;
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; sym = CLEAN[15-2*i -: 2];
      end
      @(posedge clk); #1;
      check("en_mem_before_abort", 32'(en_mem), 32'd1);
      sym = 2'b11;
      #2 rst_n = 1'b0;
      #1;
      check("abort_outputs_zero", 32'({in_ready, en_mem, cur_prv, best_st, done, busy}), 32'd0);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (30) @(posedge clk);
      check("no_done_after_abort", 32'(done_cnt), 32'(d0));
    end

    push_clean_steps();
    fq.push_back('{2'b00, 8'b1011_0000, 0});
    run_frame(CLEAN, 99, 0, 1'b0);

    check("step_queue_drained", 32'(sq.size()), 32'd0);
    check("frame_queue_drained", 32'(fq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
